// File: rtl/icache_pkg.sv
// Shared types, widths and helpers for the set-associative instruction cache.
package icache_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        READ_MEM = 1'b1
    } state_t;

    localparam int unsigned LINE_W      = 128;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned MEM_ADDR_W  = 28;
    localparam int unsigned PROC_ADDR_W = 30;
    localparam int unsigned LINE_WORDS  = LINE_W / WORD_W;

    // A cache line viewed as four instruction words, word 0 in the low bits.
    typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

    // Tag width left over once the set index is taken from the line address.
    function automatic int unsigned tag_width(input int unsigned set_bits);
        return MEM_ADDR_W - set_bits;
    endfunction

    // Storage bits per set for the replacement state (a 1-bit slot is kept even when unused).
    function automatic int unsigned plru_width(input int unsigned ways);
        return (ways == 4) ? 3 : 1;
    endfunction

endpackage

// File: rtl/icache_plru.sv
// Combinational tree pseudo-LRU for one set: victim choice and post-access update.
module icache_plru
    import icache_pkg::*;
#(
    parameter int unsigned WAYS   = 2,
    parameter int unsigned WB     = 1,
    parameter int unsigned PLRU_W = 1
) (
    input  logic [PLRU_W-1:0] plru_bits,
    input  logic [WB-1:0]     access_way,
    input  logic [WAYS-1:0]   valid,
    output logic [WB-1:0]     victim,
    output logic [PLRU_W-1:0] plru_next
);

    logic [WB-1:0] plru_pick;

    generate
        if (WAYS == 1) begin : g_one_way
            logic unused_acc;
            assign unused_acc = ^access_way;

            // Direct-mapped: only one candidate and nothing to track.
            always_comb begin
                plru_pick = '0;
                plru_next = plru_bits;
            end
        end else if (WAYS == 2) begin : g_two_way
            // The single bit names the least recently used way.
            always_comb begin
                plru_pick = WB'(plru_bits[0]);
                plru_next = PLRU_W'(~access_way[0]);
            end
        end else begin : g_four_way
            // Bit0 picks the half; bit1/bit2 pick within the left/right half; all point away from the access.
            always_comb begin
                plru_pick = plru_bits[0] ? WB'({1'b1, plru_bits[2]}) : WB'({1'b0, plru_bits[1]});
                plru_next    = plru_bits;
                plru_next[0] = ~access_way[1];
                if (access_way[1]) begin
                    plru_next[2] = ~access_way[0];
                end else begin
                    plru_next[1] = ~access_way[0];
                end
            end
        end
    endgenerate

    // An invalid way is always filled first (lowest index wins), otherwise the tree's choice.
    always_comb begin
        victim = plru_pick;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim = WB'(w);
            end
        end
    end

endmodule

// File: rtl/icache_sa.sv
// Read-only set-associative instruction cache with PLRU replacement, flush and hit/miss counters.
module icache_sa
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 4,
    parameter int unsigned SET_BITS = 2,
    parameter int unsigned WAYS     = 2,
    parameter int unsigned WAY_BITS = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   proc_reset,
    input  logic                   proc_read,
    input  logic                   proc_write,
    input  logic [PROC_ADDR_W-1:0] proc_addr,
    input  logic [WORD_W-1:0]      proc_wdata,
    input  logic                   proc_flush,
    output logic                   proc_stall,
    output logic [WORD_W-1:0]      proc_rdata,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [MEM_ADDR_W-1:0]  mem_addr,
    output logic [LINE_W-1:0]      mem_wdata,
    input  logic [LINE_W-1:0]      mem_rdata,
    input  logic                   mem_ready,
    output logic [CNT_W-1:0]       hit_cnt,
    output logic [CNT_W-1:0]       miss_cnt
);

    localparam int unsigned TAG_W  = tag_width(SET_BITS);
    localparam int unsigned WB     = (WAY_BITS == 0) ? 1 : WAY_BITS;
    localparam int unsigned PLRU_W = plru_width(WAYS);

    state_t              state_q, state_d;
    logic [WAYS-1:0]     valid_q [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][WAYS];
    line_t               data_q  [NUM_SETS][WAYS];
    logic [PLRU_W-1:0]   plru_q  [NUM_SETS];
    logic                flush_pend_q;
    logic                mem_ready_q;
    line_t               mem_rdata_q;

    logic [SET_BITS-1:0] set_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [1:0]          word_sel;
    logic                hit;
    logic [WB-1:0]       hit_way;
    logic [WB-1:0]       victim_way;
    logic [WB-1:0]       access_way;
    logic [PLRU_W-1:0]   plru_next;

    logic hit_inc, miss_inc, fill_en, plru_upd, clear_valid, pend_set, pend_clr;

    logic unused_ok;
    assign unused_ok = ^{proc_write, proc_wdata};

    assign mem_write = 1'b0;
    assign mem_wdata = '0;

    assign set_idx  = proc_addr[SET_BITS+1:2];
    assign req_tag  = proc_addr[PROC_ADDR_W-1:SET_BITS+2];
    assign word_sel = proc_addr[1:0];

    // Tag compare across the ways of the indexed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
        end
    end

    // A fill touches the victim way, a lookup touches the hit way.
    assign access_way = (state_q == READ_MEM) ? victim_way : hit_way;

    icache_plru #(
        .WAYS   (WAYS),
        .WB     (WB),
        .PLRU_W (PLRU_W)
    ) u_plru (
        .plru_bits  (plru_q[set_idx]),
        .access_way (access_way),
        .valid      (valid_q[set_idx]),
        .victim     (victim_way),
        .plru_next  (plru_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and processor/memory handshake; everything stays at 0 while reset is held.
    always_comb begin
        state_d     = state_q;
        proc_stall  = 1'b0;
        proc_rdata  = '0;
        mem_read    = 1'b0;
        mem_addr    = '0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        fill_en     = 1'b0;
        plru_upd    = 1'b0;
        clear_valid = 1'b0;
        pend_set    = 1'b0;
        pend_clr    = 1'b0;
        if (!proc_reset) begin
            case (state_q)
                IDLE: begin
                    if (proc_flush) begin
                        proc_stall  = 1'b1;
                        clear_valid = 1'b1;
                    end else if (proc_read) begin
                        if (hit) begin
                            proc_rdata = data_q[set_idx][hit_way][word_sel];
                            plru_upd   = 1'b1;
                            hit_inc    = 1'b1;
                        end else begin
                            proc_stall = 1'b1;
                            mem_read   = 1'b1;
                            mem_addr   = {req_tag, set_idx};
                            miss_inc   = 1'b1;
                            state_d    = READ_MEM;
                        end
                    end
                end
                READ_MEM: begin
                    mem_addr = {req_tag, set_idx};
                    if (proc_flush) begin
                        pend_set = 1'b1;
                    end
                    if (mem_ready_q) begin
                        proc_rdata  = mem_rdata_q[word_sel];
                        fill_en     = 1'b1;
                        plru_upd    = 1'b1;
                        pend_clr    = 1'b1;
                        clear_valid = flush_pend_q | proc_flush;
                        state_d     = IDLE;
                    end else begin
                        proc_stall = 1'b1;
                        mem_read   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Line storage, valid bits, PLRU state and deferred flush; a flush overrides a same-edge fill.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
                for (int w = 0; w < int'(WAYS); w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                end
            end
            flush_pend_q <= 1'b0;
        end else begin
            if (plru_upd) begin
                plru_q[set_idx] <= plru_next;
            end
            if (fill_en) begin
                valid_q[set_idx][victim_way] <= 1'b1;
                tag_q[set_idx][victim_way]   <= req_tag;
                data_q[set_idx][victim_way]  <= mem_rdata_q;
            end
            if (clear_valid) begin
                for (int s = 0; s < int'(NUM_SETS); s++) begin
                    valid_q[s] <= '0;
                end
            end
            if (pend_set) begin
                flush_pend_q <= 1'b1;
            end
            if (pend_clr) begin
                flush_pend_q <= 1'b0;
            end
        end
    end

    // Memory response is registered before use.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            mem_ready_q <= mem_ready;
            mem_rdata_q <= line_t'(mem_rdata);
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_inc && !(&hit_cnt)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (miss_inc && !(&miss_cnt)) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa: directed vector table, hand sequences, randomized run vs LRU model.
module tb_icache_sa;

    logic         clk = 1'b0;
    logic         proc_reset, proc_read, proc_write, proc_flush;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall, mem_read, mem_write, mem_ready;
    logic [31:0]  proc_rdata;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic [31:0]  hit_cnt, miss_cnt;

    logic         unused_stall2, unused_mrd2, unused_mwr2;
    logic [31:0]  unused_rdata2;
    logic [27:0]  unused_maddr2;
    logic [127:0] unused_mwdata2;
    logic [1:0]   hit_cnt2, miss_cnt2;

    always #5 clk = ~clk;

    icache_sa dut (
        .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_flush(proc_flush),
        .proc_stall(proc_stall), .proc_rdata(proc_rdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, to reach counter saturation quickly.
    icache_sa #(.CNT_W(2)) dut_sat (
        .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_flush(proc_flush),
        .proc_stall(unused_stall2), .proc_rdata(unused_rdata2), .mem_read(unused_mrd2),
        .mem_write(unused_mwr2), .mem_addr(unused_maddr2), .mem_wdata(unused_mwdata2),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Backing memory contents: unique word per (line, word) except the documented example line.
    function automatic logic [127:0] line_data(input logic [27:0] la);
        logic [127:0] d;
        if (la == 28'h4) begin
            d = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
        end else begin
            for (int w = 0; w < 4; w++) d[w*32 +: 32] = {2'(w), 2'b10, la};
        end
        return d;
    endfunction

    function automatic logic [31:0] word_of(input logic [29:0] a);
        logic [127:0] d;
        d = line_data(a[29:2]);
        return d[32*int'(a[1:0]) +: 32];
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    // Reference model: per set, two ways with valid/tag plus the most recently used way.
    logic        m_valid [4][2];
    logic [25:0] m_tag   [4][2];
    int          m_mru   [4];
    int          m_hits, m_misses;

    function automatic void model_reset();
        for (int s = 0; s < 4; s++) begin
            m_valid[s][0] = 1'b0; m_valid[s][1] = 1'b0;
            m_tag[s][0] = '0;     m_tag[s][1] = '0;
            m_mru[s] = 1;
        end
        m_hits = 0;
        m_misses = 0;
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < 4; s++) begin
            m_valid[s][0] = 1'b0; m_valid[s][1] = 1'b0;
        end
    endfunction

    function automatic int model_lookup(input logic [29:0] a);
        int s;
        s = int'(a[3:2]);
        for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == a[29:4]) return w;
        return -1;
    endfunction

    function automatic int model_victim(input int s);
        if (!m_valid[s][0]) return 0;
        if (!m_valid[s][1]) return 1;
        return 1 - m_mru[s];
    endfunction

    // Memory responder: answers a held mem_read after lat cycles, once per request.
    bit mem_auto  = 1'b0;
    int lat       = 3;
    int rcnt      = 0;
    bit wait_drop = 1'b0;

    task automatic next_cycle();
        logic         nr;
        logic [127:0] nd;
        nr = 1'b0;
        nd = '0;
        if (mem_auto) begin
            if (mem_ready) wait_drop = 1'b1;
            else if (wait_drop && !mem_read) wait_drop = 1'b0;
            if (mem_read && !wait_drop) begin
                rcnt++;
                if (rcnt >= lat) begin
                    nr = 1'b1;
                    nd = line_data(mem_addr);
                    rcnt = 0;
                end
            end else begin
                rcnt = 0;
            end
        end
        @(posedge clk);
        #1;
        mem_ready = nr;
        mem_rdata = nd;
    endtask

    task automatic reset_dut();
        proc_reset = 1'b1; proc_read = 1'b0; proc_flush = 1'b0; proc_addr = '0;
        proc_write = 1'b0; proc_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        mem_auto = 1'b0; rcnt = 0; wait_drop = 1'b0;
        @(negedge clk);
        chk("rst_stall", 32'(proc_stall), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_rdata", proc_rdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        next_cycle();
        next_cycle();
        proc_reset = 1'b0;
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        model_reset();
    endtask

    task automatic flush_idle();
        proc_flush = 1'b1;
        proc_read  = 1'b0;
        @(negedge clk);
        chk("flush_stall", 32'(proc_stall), 32'd1);
        chk("flush_mem_read", 32'(mem_read), 32'd0);
        next_cycle();
        proc_flush = 1'b0;
        model_flush();
    endtask

    // One fetch transaction: hit in the same cycle, or miss with fill and lat+1 stall cycles.
    task automatic read_txn(input logic [29:0] a, input bit exp_hit, input bit flush_mid);
        int s, cyc, hw, v;
        logic [31:0] w;
        s  = int'(a[3:2]);
        w  = word_of(a);
        hw = model_lookup(a);
        proc_read  = 1'b1;
        proc_addr  = a;
        proc_flush = 1'b0;
        @(negedge clk);
        chk("mem_write_tied", 32'(mem_write), 32'd0);
        if (exp_hit) begin
            chk("hit_stall", 32'(proc_stall), 32'd0);
            chk("hit_mem_read", 32'(mem_read), 32'd0);
            chk("hit_rdata", proc_rdata, w);
            m_hits++;
            if (hw >= 0) m_mru[s] = hw;
            next_cycle();
        end else begin
            chk("miss_stall", 32'(proc_stall), 32'd1);
            chk("miss_mem_read", 32'(mem_read), 32'd1);
            chk("miss_mem_addr", 32'(mem_addr), 32'(a[29:2]));
            m_misses++;
            next_cycle();
            cyc = 1;
            proc_flush = flush_mid;
            @(negedge clk);
            while (proc_stall && cyc < 60) begin
                chk("fill_hold_addr", 32'(mem_addr), 32'(a[29:2]));
                next_cycle();
                cyc++;
                proc_flush = 1'b0;
                @(negedge clk);
            end
            chk("fill_latency", 32'(cyc), 32'(lat + 1));
            chk("fill_rdata", proc_rdata, w);
            chk("fill_mem_read", 32'(mem_read), 32'd0);
            v = model_victim(s);
            m_valid[s][v] = 1'b1;
            m_tag[s][v]   = a[29:4];
            m_mru[s]      = v;
            if (flush_mid) model_flush();
            next_cycle();
        end
        proc_read  = 1'b0;
        proc_flush = 1'b0;
        chk("hit_cnt", hit_cnt, 32'(m_hits));
        chk("miss_cnt", miss_cnt, 32'(m_misses));
        chk("hit_cnt_sat", 32'(hit_cnt2), 32'(sat3(m_hits)));
        chk("miss_cnt_sat", 32'(miss_cnt2), 32'(sat3(m_misses)));
    endtask

    typedef struct {
        logic         rd;
        logic         fl;
        logic [29:0]  addr;
        logic         rdy;
        logic [127:0] rdat;
        logic         e_stall;
        logic         e_mrd;
        logic [27:0]  e_maddr;
        logic         c_rdata;
        logic [31:0]  e_rdata;
        int           e_hits;
        int           e_miss;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic fl, input logic [29:0] addr,
                                input logic rdy, input logic [127:0] rdat, input logic e_stall,
                                input logic e_mrd, input logic [27:0] e_maddr, input logic c_rdata,
                                input logic [31:0] e_rdata, input int e_hits, input int e_miss);
        vec_t v;
        v.rd = rd; v.fl = fl; v.addr = addr; v.rdy = rdy; v.rdat = rdat;
        v.e_stall = e_stall; v.e_mrd = e_mrd; v.e_maddr = e_maddr;
        v.c_rdata = c_rdata; v.e_rdata = e_rdata; v.e_hits = e_hits; v.e_miss = e_miss;
        return v;
    endfunction

    vec_t vecs[17];

    initial begin
        logic [127:0] l4, l5, junk;
        logic [29:0]  ra;
        int           hw;
        l4   = line_data(28'h4);
        l5   = line_data(28'h5);
        junk = {4{32'hFFFF_FFFF}};

        // Cold miss, same-line hit, flush in IDLE, stale ready in IDLE discarded.
        vecs[0]  = mk(1, 0, 30'h10, 0, '0,   1, 1, 28'h4, 0, 32'h0,         0, 0);
        vecs[1]  = mk(1, 0, 30'h10, 0, '0,   1, 1, 28'h4, 0, 32'h0,         0, 1);
        vecs[2]  = mk(1, 0, 30'h10, 0, '0,   1, 1, 28'h4, 0, 32'h0,         0, 1);
        vecs[3]  = mk(1, 0, 30'h10, 1, l4,   1, 1, 28'h4, 0, 32'h0,         0, 1);
        vecs[4]  = mk(1, 0, 30'h10, 0, '0,   0, 0, 28'h0, 1, 32'hAAAA_AAAA, 0, 1);
        vecs[5]  = mk(1, 0, 30'h11, 0, '0,   0, 0, 28'h0, 1, 32'hBBBB_BBBB, 0, 1);
        vecs[6]  = mk(0, 0, 30'h00, 0, '0,   0, 0, 28'h0, 1, 32'h0,         1, 1);
        vecs[7]  = mk(0, 1, 30'h00, 0, '0,   1, 0, 28'h0, 0, 32'h0,         1, 1);
        vecs[8]  = mk(1, 0, 30'h10, 0, '0,   1, 1, 28'h4, 0, 32'h0,         1, 1);
        vecs[9]  = mk(1, 0, 30'h10, 1, l4,   1, 1, 28'h4, 0, 32'h0,         1, 2);
        vecs[10] = mk(1, 0, 30'h10, 0, '0,   0, 0, 28'h0, 1, 32'hAAAA_AAAA, 1, 2);
        vecs[11] = mk(0, 0, 30'h00, 1, junk, 0, 0, 28'h0, 1, 32'h0,         1, 2);
        vecs[12] = mk(1, 0, 30'h15, 0, '0,   1, 1, 28'h5, 0, 32'h0,         1, 2);
        vecs[13] = mk(1, 0, 30'h15, 0, '0,   1, 1, 28'h5, 0, 32'h0,         1, 3);
        vecs[14] = mk(1, 0, 30'h15, 1, l5,   1, 1, 28'h5, 0, 32'h0,         1, 3);
        vecs[15] = mk(1, 0, 30'h15, 0, '0,   0, 0, 28'h0, 1, l5[63:32],     1, 3);
        vecs[16] = mk(0, 0, 30'h00, 0, '0,   0, 0, 28'h0, 1, 32'h0,         1, 3);

        reset_dut();

        for (int i = 0; i < 17; i++) begin
            proc_read  = vecs[i].rd;
            proc_flush = vecs[i].fl;
            proc_addr  = vecs[i].addr;
            mem_ready  = vecs[i].rdy;
            mem_rdata  = vecs[i].rdat;
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), 32'(proc_stall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_mem_read", i), 32'(mem_read), 32'(vecs[i].e_mrd));
            if (vecs[i].e_mrd) chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_maddr));
            if (vecs[i].c_rdata) chk($sformatf("vec%0d_rdata", i), proc_rdata, vecs[i].e_rdata);
            chk($sformatf("vec%0d_hit_cnt", i), hit_cnt, 32'(vecs[i].e_hits));
            chk($sformatf("vec%0d_miss_cnt", i), miss_cnt, 32'(vecs[i].e_miss));
            next_cycle();
        end

        // LRU eviction within set 0.
        reset_dut();
        mem_auto = 1'b1;
        lat = 3;
        read_txn(30'h10, 0, 0);
        read_txn(30'h20, 0, 0);
        read_txn(30'h10, 1, 0);
        read_txn(30'h30, 0, 0);
        read_txn(30'h10, 1, 0);
        read_txn(30'h20, 0, 0);
        chk("lru_final_hits", hit_cnt, 32'd2);
        chk("lru_final_misses", miss_cnt, 32'd4);

        // Flush while a fill is outstanding.
        reset_dut();
        mem_auto = 1'b1;
        lat = 2;
        read_txn(30'h10, 0, 1);
        read_txn(30'h10, 0, 0);

        // Reset in the middle of a fill, with a late memory response.
        reset_dut();
        mem_auto = 1'b1;
        lat = 2;
        read_txn(30'h10, 0, 0);
        mem_auto = 1'b0;
        proc_read = 1'b1;
        proc_addr = 30'h40;
        @(negedge clk);
        chk("rmf_miss_stall", 32'(proc_stall), 32'd1);
        chk("rmf_miss_mem_read", 32'(mem_read), 32'd1);
        next_cycle();
        proc_reset = 1'b1;
        @(negedge clk);
        chk("rmf_rst_stall", 32'(proc_stall), 32'd0);
        chk("rmf_rst_mem_read", 32'(mem_read), 32'd0);
        next_cycle();
        proc_reset = 1'b0;
        proc_read  = 1'b0;
        @(negedge clk);
        chk("rmf_hit_cnt", hit_cnt, 32'd0);
        chk("rmf_miss_cnt", miss_cnt, 32'd0);
        chk("rmf_idle_stall", 32'(proc_stall), 32'd0);
        next_cycle();
        mem_ready = 1'b1;
        mem_rdata = line_data(28'h10);
        @(negedge clk);
        chk("rmf_late_stall", 32'(proc_stall), 32'd0);
        chk("rmf_late_mem_read", 32'(mem_read), 32'd0);
        next_cycle();
        proc_read = 1'b1;
        proc_addr = 30'h10;
        @(negedge clk);
        chk("rmf_reread_stall", 32'(proc_stall), 32'd1);
        chk("rmf_reread_mem_read", 32'(mem_read), 32'd1);
        chk("rmf_reread_addr", 32'(mem_addr), 32'h4);
        next_cycle();
        @(negedge clk);
        chk("rmf_stale_ready_ignored", 32'(proc_stall), 32'd1);

        // Randomized traffic against the LRU model.
        reset_dut();
        mem_auto = 1'b1;
        for (int t = 0; t < 400; t++) begin
            proc_write = 1'($urandom_range(0, 1));
            proc_wdata = $urandom;
            if ($urandom_range(0, 11) == 0) begin
                flush_idle();
            end else begin
                ra  = 30'({2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))});
                lat = int'($urandom_range(1, 4));
                hw  = model_lookup(ra);
                read_txn(ra, hw >= 0, (hw < 0) && ($urandom_range(0, 15) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised read-only, set-associative instruction cache between the fetch stage and the L2/memory port.
- Next generation of the team's direct-mapped ICache:
  - configurable sets and ways
  - tree pseudo-LRU replacement
  - whole-cache flush
  - hit/miss performance counters
- Keeps the same processor and 128-bit line memory interface, so it drops in unchanged.

Parameters:
- NUM_SETS, 4, number of sets; power of two, at least 2.
- SET_BITS, 2, log2(NUM_SETS).
- WAYS, 2, associativity; legal values 1, 2, 4.
- WAY_BITS, 1, log2(WAYS); 0 when WAYS=1, handled by generate.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- proc_reset  in  1  synchronous, active-high reset.
- proc_read  in  1  fetch request.
- proc_write  in  1  ignored; the cache is read-only.
- proc_addr  in  30  word address: [1:0] word-in-line, [SET_BITS+1:2] set index, [29:SET_BITS+2] tag.
- proc_wdata  in  32  ignored.
- proc_flush  in  1  invalidate all lines.
- proc_stall  out  1  fetch must hold its request.
- proc_rdata  out  32  instruction word.
- mem_read  out  1  line read request.
- mem_write  out  1  tied 0.
- mem_addr  out  28  line address {tag,index}.
- mem_wdata  out  128  tied 0.
- mem_rdata  in  128  returned line.
- mem_ready  in  1  line valid.
- hit_cnt  out  CNT_W  saturating hit counter.
- miss_cnt  out  CNT_W  saturating miss counter.

Behaviour:
- Reset values:
  - Synchronous reset, same edge: state=IDLE, all valid=0, tags/data=0, PLRU bits=0, flush_pend=0, mem_ready_q=0, mem_rdata_q=0, counters=0.
  - Outputs during reset are combinational defaults: all 0.
- Registered memory inputs: mem_ready and mem_rdata are captured every cycle into mem_ready_q and mem_rdata_q. Only the _q copies are consumed, which adds one cycle of fill latency.
- IDLE, no read: all outputs 0.
- IDLE, flush=1:
  - proc_stall=1 that cycle; no lookup; no counter change.
  - All valid bits cleared at the edge.
  - A read held into the next cycle proceeds as a normal lookup.
- IDLE, read, hit (any way with valid and matching tag in the indexed set):
  - Same cycle: proc_stall=0 and proc_rdata = word[proc_addr[1:0]] of the hit way.
  - PLRU updated to point away from the hit way.
  - hit_cnt +1.
  - Multiple matching ways are illegal.
- IDLE, read, miss:
  - Same cycle: proc_stall=1, mem_read=1, mem_addr={tag,index}.
  - Next state READ_MEM; miss_cnt +1 once per miss.
- READ_MEM, mem_ready_q=0: hold mem_read=1, the same mem_addr, and proc_stall=1.
- READ_MEM, mem_ready_q=1:
  - Same cycle: proc_stall=0, mem_read=0, proc_rdata = word from mem_rdata_q.
  - Victim way = lowest-index invalid way, else the PLRU victim. It is written with data, tag and valid=1.
  - PLRU updated away from the victim. Next state IDLE.
- PLRU encoding:
  - WAYS=2: 1 bit naming the LRU way.
  - WAYS=4: 3-bit tree. Bit0 selects the half; bit1 and bit2 select within the left/right half.
  - WAYS=1: victim is always way 0.
- Flush during READ_MEM:
  - Latched into flush_pend; the fill is not aborted.
  - At the fill-completion edge, all valid bits are cleared, including the just-filled line. The fetched word is still delivered.
  - flush_pend is cleared at that edge.
- A mem_ready_q seen in IDLE is discarded.
- The processor must hold proc_addr and proc_read while proc_stall=1. Behaviour is undefined otherwise.
- Counters saturate at all-ones.
- Reset mid-fill: immediate return to IDLE with everything invalid. Late memory responses are discarded as above.

Decomposition:
- Package icache_pkg holds:
  - state enum {IDLE, READ_MEM}
  - LINE_W=128, WORD_W=32, MEM_ADDR_W=28
  - helper functions for the tag width: 28-SET_BITS.
- Sub-module icache_plru:
  - Purely combinational per-set logic; WAYS parameter.
  - Inputs: current PLRU bits, access way, valid vector.
  - Outputs: victim way, next PLRU bits.
- The parent holds the PLRU storage.

Test Plan:
- Cold miss (WAYS=2, NUM_SETS=4):
  - Stimulus: read 30'h10; memory returns 128'hDDDD_CCCC_BBBB_AAAA... 4 words W3..W0 after 3 cycles.
  - Response: mem_read=1 with mem_addr=28'h4; stall released exactly one cycle after mem_ready; proc_rdata=W0; miss_cnt=1.
- Same-line hit: read 30'h11 next -> stall=0 in the same cycle; proc_rdata=W1; hit_cnt=1.
- LRU eviction:
  - Stimulus: fill 30'h10 then 30'h20 (both set 0); re-read 30'h10 (hit); read 30'h30 (miss).
  - Response: 30'h20 is evicted, so 30'h10 hits and 30'h20 misses; final miss_cnt=4, hit_cnt=2.
- Flush in IDLE: pulse proc_flush -> stall=1 for one cycle; read 30'h10 then misses with mem_addr=28'h4.
- Flush during fill: assert flush while in READ_MEM -> the word is still returned; an immediate re-read of the same address misses.
- Reset mid-fill:
  - Stimulus: proc_reset in READ_MEM; mem_ready arrives 2 cycles later.
  - Response: state IDLE; counters 0; mem_ready ignored; the next read misses.
